// File: rtl/ps2_kb_matrix.sv
// PS/2 keyboard receiver and scancode decoder that maintains a 40-key matrix state
// (8 half-rows x 5 keys, bit index = row*5 + col).
module ps2_kb_matrix #(
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [39:0] kb_state,
    output logic [7:0]  scan_code,
    output logic        scan_valid,
    output logic        frame_err
);

    localparam int unsigned TW      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned KEYS    = 40;
    localparam int unsigned BITS_W  = 4;
    localparam int unsigned FRAME_W = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    logic [2:0]          clk_sync;   // [0],[1] synchronizer, [2] history
    logic [1:0]          data_sync;
    logic [FRAME_W-1:0]  frame_sr;
    logic [BITS_W-1:0]   bit_cnt;
    logic [TW-1:0]       tmo_cnt;
    dec_state_t          state;
    dec_state_t          state_next;
    logic [KEYS-1:0]     kb_next;

    logic                fall_c;
    logic                last_bit_c;
    logic [FRAME_W-1:0]  frame_full_c;
    logic [7:0]          byte_c;
    logic                frame_pass_c;
    logic                byte_ok_c;
    logic                frame_bad_c;
    logic [6:0]          key_hit_idx_c;
    logic [KEYS-1:0]     key_mask_c;

    // Scancode -> {hit, matrix index}
    function automatic logic [6:0] key_index(input logic [7:0] code);
        case (code)
            8'h12: key_index = {1'b1, 6'd0};
            8'h1A: key_index = {1'b1, 6'd1};
            8'h22: key_index = {1'b1, 6'd2};
            8'h21: key_index = {1'b1, 6'd3};
            8'h2A: key_index = {1'b1, 6'd4};
            8'h1C: key_index = {1'b1, 6'd5};
            8'h1B: key_index = {1'b1, 6'd6};
            8'h23: key_index = {1'b1, 6'd7};
            8'h2B: key_index = {1'b1, 6'd8};
            8'h34: key_index = {1'b1, 6'd9};
            8'h15: key_index = {1'b1, 6'd10};
            8'h1D: key_index = {1'b1, 6'd11};
            8'h24: key_index = {1'b1, 6'd12};
            8'h2D: key_index = {1'b1, 6'd13};
            8'h2C: key_index = {1'b1, 6'd14};
            8'h16: key_index = {1'b1, 6'd15};
            8'h1E: key_index = {1'b1, 6'd16};
            8'h26: key_index = {1'b1, 6'd17};
            8'h25: key_index = {1'b1, 6'd18};
            8'h2E: key_index = {1'b1, 6'd19};
            8'h45: key_index = {1'b1, 6'd20};
            8'h46: key_index = {1'b1, 6'd21};
            8'h3E: key_index = {1'b1, 6'd22};
            8'h3D: key_index = {1'b1, 6'd23};
            8'h36: key_index = {1'b1, 6'd24};
            8'h4D: key_index = {1'b1, 6'd25};
            8'h44: key_index = {1'b1, 6'd26};
            8'h43: key_index = {1'b1, 6'd27};
            8'h3C: key_index = {1'b1, 6'd28};
            8'h35: key_index = {1'b1, 6'd29};
            8'h5A: key_index = {1'b1, 6'd30};
            8'h4B: key_index = {1'b1, 6'd31};
            8'h42: key_index = {1'b1, 6'd32};
            8'h3B: key_index = {1'b1, 6'd33};
            8'h33: key_index = {1'b1, 6'd34};
            8'h29: key_index = {1'b1, 6'd35};
            8'h59: key_index = {1'b1, 6'd36};
            8'h3A: key_index = {1'b1, 6'd37};
            8'h31: key_index = {1'b1, 6'd38};
            8'h32: key_index = {1'b1, 6'd39};
            default: key_index = 7'd0;
        endcase
    endfunction

    assign fall_c       = clk_sync[2] & ~clk_sync[1];
    assign last_bit_c   = (bit_cnt == BITS_W'(10));
    assign frame_full_c = {data_sync[1], frame_sr[FRAME_W-1:1]};
    assign byte_c       = frame_full_c[8:1];
    assign frame_pass_c = ~frame_full_c[0] & (^frame_full_c[9:1]) & frame_full_c[10];
    assign byte_ok_c    = fall_c & last_bit_c & frame_pass_c;
    assign frame_bad_c  = fall_c & last_bit_c & ~frame_pass_c;
    assign key_hit_idx_c = key_index(byte_c);
    assign key_mask_c   = key_hit_idx_c[6] ? (KEYS'(1) << key_hit_idx_c[5:0]) : '0;

    // Line synchronizers, frame shifter, bit counter and mid-frame timeout
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync   <= 3'b111;
            data_sync  <= 2'b11;
            frame_sr   <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_c) begin
                tmo_cnt  <= '0;
                frame_sr <= frame_full_c;
                if (last_bit_c) begin
                    bit_cnt <= '0;
                    if (frame_pass_c) begin
                        scan_code  <= byte_c;
                        scan_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + BITS_W'(1);
                end
            end else if (bit_cnt == '0) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                tmo_cnt   <= '0;
                bit_cnt   <= '0;
                frame_err <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // Decoder state and key matrix registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            kb_state <= '0;
        end else begin
            state    <= state_next;
            kb_state <= kb_next;
        end
    end

    // Make/break/extended decoder; only valid bytes advance it
    always_comb begin
        state_next = state;
        kb_next    = kb_state;
        if (frame_bad_c) begin
            state_next = IDLE;
        end else if (byte_ok_c) begin
            case (state)
                IDLE: begin
                    if (byte_c == 8'hE0) begin
                        state_next = EXT;
                    end else if (byte_c == 8'hF0) begin
                        state_next = BRK;
                    end else if (byte_c == 8'h00 || byte_c == 8'hFF) begin
                        kb_next = '0;
                    end else begin
                        kb_next = kb_state | key_mask_c;
                    end
                end
                BRK: begin
                    kb_next    = kb_state & ~key_mask_c;
                    state_next = IDLE;
                end
                EXT:     state_next = (byte_c == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kb_matrix.sv
// Bench for ps2_kb_matrix: directed vector table, timeout/reset sequences and
// randomized byte streams checked against a keyboard-level reference model.
module tb_ps2_kb_matrix;

    localparam int unsigned TMO = 200;
    localparam int unsigned HB  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [39:0] kb_state;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_err   = 0;

    ps2_kb_matrix #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb_state(kb_state), .scan_code(scan_code),
        .scan_valid(scan_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scan_valid) n_valid++;
        if (frame_err)  n_err++;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] key_tab [40] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h59, 8'h3A, 8'h31, 8'h32
    };

    // Reference keyboard model
    logic [39:0] m_kb;
    logic [7:0]  m_code;
    bit          m_ext, m_brk;

    function automatic int key_pos(input logic [7:0] b);
        for (int i = 0; i < 40; i++) if (key_tab[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int p;
        p = key_pos(b);
        m_code = b;
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1; else m_ext = 0;
        end else if (m_brk) begin
            if (p >= 0) m_kb[p] = 1'b0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_kb = '0;
        end else if (p >= 0) begin
            m_kb[p] = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HB) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HB) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (HB) @(posedge clk);
    endtask

    task automatic do_frame(input logic [7:0] d, input logic bad, input logic [39:0] exp_kb,
                            input logic [7:0] exp_code, input int exp_v, input int exp_e);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(d, bad);
        @(negedge clk);
        check($sformatf("kb_state after %h", d), kb_state, exp_kb);
        check($sformatf("scan_code after %h", d), 40'(scan_code), 40'(exp_code));
        check($sformatf("scan_valid count after %h", d), 40'(n_valid - v0), 40'(exp_v));
        check($sformatf("frame_err count after %h", d), 40'(n_err - e0), 40'(exp_e));
    endtask

    typedef struct {
        logic [7:0]  code;
        logic        bad;
        logic [39:0] kb;
        logic [7:0]  sc;
        int          nv;
        int          ne;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int e0, wait_cyc;
        logic [7:0] b;
        logic bad;

        vecs[0]  = '{8'h1C, 1'b0, 40'h0000000020, 8'h1C, 1, 0};
        vecs[1]  = '{8'hF0, 1'b0, 40'h0000000020, 8'hF0, 1, 0};
        vecs[2]  = '{8'h1C, 1'b0, 40'h0000000000, 8'h1C, 1, 0};
        vecs[3]  = '{8'h12, 1'b0, 40'h0000000001, 8'h12, 1, 0};
        vecs[4]  = '{8'h29, 1'b0, 40'h0800000001, 8'h29, 1, 0};
        vecs[5]  = '{8'hE0, 1'b0, 40'h0800000001, 8'hE0, 1, 0};
        vecs[6]  = '{8'hF0, 1'b0, 40'h0800000001, 8'hF0, 1, 0};
        vecs[7]  = '{8'h29, 1'b0, 40'h0800000001, 8'h29, 1, 0};
        vecs[8]  = '{8'hF0, 1'b0, 40'h0800000001, 8'hF0, 1, 0};
        vecs[9]  = '{8'h29, 1'b0, 40'h0000000001, 8'h29, 1, 0};
        vecs[10] = '{8'h22, 1'b1, 40'h0000000001, 8'h29, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset kb_state", kb_state, 40'h0);
        check("reset scan_code", 40'(scan_code), 40'h0);
        check("reset pulses", 40'({scan_valid, frame_err}), 40'h0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        foreach (vecs[i])
            do_frame(vecs[i].code, vecs[i].bad, vecs[i].kb, vecs[i].sc, vecs[i].nv, vecs[i].ne);

        // Abandoned frame: 5 bits then silence
        e0 = n_err;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc = 0;
        while (n_err == e0 && wait_cyc < 4 * TMO) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("timeout frame_err", 40'(n_err - e0), 40'd1);
        check("timeout kb_state", kb_state, 40'h1);
        do_frame(8'h15, 1'b0, 40'h0000000401, 8'h15, 1, 0);
        do_frame(8'h00, 1'b0, 40'h0000000000, 8'h00, 1, 0);

        // Reset in the middle of a frame
        do_frame(8'h1C, 1'b0, 40'h0000000020, 8'h1C, 1, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midframe reset kb_state", kb_state, 40'h0);
        check("midframe reset scan_code", 40'(scan_code), 40'h0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        do_frame(8'h1C, 1'b0, 40'h0000000020, 8'h1C, 1, 0);

        // Randomized byte stream against the reference model
        m_kb = 40'h20; m_code = 8'h1C; m_ext = 0; m_brk = 0;
        for (int n = 0; n < 50; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 10)      b = key_tab[$urandom_range(0, 39)];
            else if (r < 13) b = 8'hF0;
            else if (r < 15) b = 8'hE0;
            else if (r == 15) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            else             b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            if (bad) begin
                m_ext = 0; m_brk = 0;
                do_frame(b, 1'b1, m_kb, m_code, 0, 1);
            end else begin
                model_byte(b);
                do_frame(b, 1'b0, m_kb, m_code, 1, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
